// File: rtl/seq_loader_avalon.sv
// Avalon-MM loader that buffers two packed DNA sequences and their lengths, then
// runs and holds the med_solver core. Optional feature macro: LOAD_CHECKSUM_EN.
module seq_loader_avalon #(
  parameter int MAX_LEN1 = 46,
  parameter int MAX_LEN2 = 46
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              avm_main_address,
  input  logic [7:0]              avm_main_byteenable,
  input  logic                    avm_main_read,
  output logic [63:0]             avm_main_readdata,
  input  logic                    avm_main_write,
  input  logic [63:0]             avm_main_writedata,
  output logic                    solver_rst,
  output logic [7:0]              len1,
  output logic [7:0]              len2,
  output logic [2*MAX_LEN1-1:0]   seq1,
  output logic [2*MAX_LEN2-1:0]   seq2,
  input  logic                    finished
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [5:0] A_CTRL = 6'd0;
  localparam logic [5:0] A_LEN  = 6'd1;
  localparam logic [5:0] A_SEQ1 = 6'd2;
  localparam logic [5:0] A_SEQ2 = 6'd3;
  localparam logic [5:0] A_CSUM = 6'd4;
  localparam logic [7:0] L1 = 8'(MAX_LEN1);
  localparam logic [7:0] L2 = 8'(MAX_LEN2);

  state_t                  r_state;
  logic                    r_solver_rst;
  logic                    r_err;
  logic                    r_done;
  logic [7:0]              r_wptr1;
  logic [7:0]              r_wptr2;
  logic [7:0]              r_len1_reg;
  logic [7:0]              r_len2_reg;
  logic [7:0]              r_len1;
  logic [7:0]              r_len2;
  logic [2*MAX_LEN1-1:0]   r_seq1;
  logic [2*MAX_LEN2-1:0]   r_seq2;

  logic                    w_wr_ctrl;
  logic                    w_start;
  logic                    w_clear;
  logic                    w_wr_len;
  logic                    w_wr_seq1;
  logic                    w_wr_seq2;
  logic                    w_busy;
  logic                    w_room1;
  logic                    w_room2;
  logic                    w_len_ok;
  logic [8:0]              w_sum1;
  logic [8:0]              w_sum2;
  logic [7:0]              w_wptr1_next;
  logic [7:0]              w_wptr2_next;
  logic [2*MAX_LEN1-1:0]   w_seq1_next;
  logic [2*MAX_LEN2-1:0]   w_seq2_next;
  logic [63:0]             w_rdata;
  logic                    w_unused_be;

  assign w_unused_be = ^avm_main_byteenable;

  assign w_wr_ctrl = avm_main_write && (avm_main_address == A_CTRL);
  assign w_start   = w_wr_ctrl && avm_main_writedata[0];
  assign w_clear   = w_wr_ctrl && avm_main_writedata[1];
  assign w_wr_len  = avm_main_write && (avm_main_address == A_LEN);
  assign w_wr_seq1 = avm_main_write && (avm_main_address == A_SEQ1);
  assign w_wr_seq2 = avm_main_write && (avm_main_address == A_SEQ2);
  assign w_busy    = (r_state == ST_RUN);

  assign w_room1 = (r_wptr1 != L1);
  assign w_room2 = (r_wptr2 != L2);

  // Pointers never exceed the buffer size, so min(wptr, MAX_LEN) is just wptr.
  assign w_len_ok = (r_len1_reg != 8'd0) && (r_len1_reg <= r_wptr1) &&
                    (r_len2_reg != 8'd0) && (r_len2_reg <= r_wptr2);

  assign w_sum1       = {1'b0, r_wptr1} + 9'd32;
  assign w_sum2       = {1'b0, r_wptr2} + 9'd32;
  assign w_wptr1_next = (w_sum1 > {1'b0, L1}) ? L1 : w_sum1[7:0];
  assign w_wptr2_next = (w_sum2 > {1'b0, L2}) ? L2 : w_sum2[7:0];

  // Bases landing at or beyond the buffer end are simply not stored.
  always_comb begin : seq1_insert
    logic [7:0] off;
    off         = 8'd0;
    w_seq1_next = r_seq1;
    for (int k = 0; k < MAX_LEN1; k++) begin
      off = 8'(k) - r_wptr1;
      if ((8'(k) >= r_wptr1) && (off < 8'd32))
        w_seq1_next[2*k +: 2] = avm_main_writedata[{off[4:0], 1'b0} +: 2];
    end
  end

  always_comb begin : seq2_insert
    logic [7:0] off;
    off         = 8'd0;
    w_seq2_next = r_seq2;
    for (int k = 0; k < MAX_LEN2; k++) begin
      off = 8'(k) - r_wptr2;
      if ((8'(k) >= r_wptr2) && (off < 8'd32))
        w_seq2_next[2*k +: 2] = avm_main_writedata[{off[4:0], 1'b0} +: 2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_solver_rst <= 1'b1;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_wptr1      <= 8'd0;
      r_wptr2      <= 8'd0;
      r_len1_reg   <= 8'd0;
      r_len2_reg   <= 8'd0;
      r_len1       <= 8'd0;
      r_len2       <= 8'd0;
      r_seq1       <= '0;
      r_seq2       <= '0;
    end else if (w_clear) begin
      // CLEAR beats a simultaneous START and aborts a running solver.
      r_state      <= ST_IDLE;
      r_solver_rst <= 1'b1;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_wptr1      <= 8'd0;
      r_wptr2      <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_seq1) begin
            if (w_room1) begin
              r_seq1  <= w_seq1_next;
              r_wptr1 <= w_wptr1_next;
            end else begin
              r_err <= 1'b1;
            end
          end
          if (w_wr_seq2) begin
            if (w_room2) begin
              r_seq2  <= w_seq2_next;
              r_wptr2 <= w_wptr2_next;
            end else begin
              r_err <= 1'b1;
            end
          end
          if (w_wr_len) begin
            r_len1_reg <= avm_main_writedata[7:0];
            r_len2_reg <= avm_main_writedata[15:8];
          end
          if (w_start) begin
            if (w_len_ok) begin
              r_len1       <= r_len1_reg;
              r_len2       <= r_len2_reg;
              r_state      <= ST_RUN;
              r_solver_rst <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_wr_seq1 || w_wr_seq2 || w_wr_len || w_start)
            r_err <= 1'b1;
          if (finished) begin
            r_state      <= ST_DONE;
            r_solver_rst <= 1'b1;
            r_done       <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_wr_seq1 || w_wr_seq2 || w_wr_len || w_start)
            r_err <= 1'b1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_solver_rst <= 1'b1;
        end
      endcase
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [15:0] r_cksum;
  logic [15:0] w_fold;
  logic        w_seq_accept;

  assign w_fold = avm_main_writedata[15:0]  ^ avm_main_writedata[31:16] ^
                  avm_main_writedata[47:32] ^ avm_main_writedata[63:48];
  assign w_seq_accept = (r_state == ST_IDLE) &&
                        ((w_wr_seq1 && w_room1) || (w_wr_seq2 && w_room2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cksum <= 16'd0;
    else if (w_clear)
      r_cksum <= 16'd0;
    else if (w_seq_accept)
      r_cksum <= {r_cksum[14:0], r_cksum[15]} ^ w_fold;
  end
`endif

  always_comb begin
    w_rdata = 64'd0;
    if (avm_main_read) begin
      case (avm_main_address)
        A_CTRL: w_rdata = {32'd0, r_wptr2, r_wptr1, 6'd0, r_state, 5'd0,
                           r_err, r_done, w_busy};
        A_LEN:  w_rdata = {48'd0, r_len2_reg, r_len1_reg};
`ifdef LOAD_CHECKSUM_EN
        A_CSUM: w_rdata = {48'd0, r_cksum};
`else
        A_CSUM: w_rdata = 64'd0;
`endif
        default: w_rdata = 64'd0;
      endcase
    end
  end

  assign avm_main_readdata = w_rdata;
  assign solver_rst        = r_solver_rst;
  assign len1              = r_len1;
  assign len2              = r_len2;
  assign seq1              = r_seq1;
  assign seq2              = r_seq2;

endmodule
